// File: rtl/srl_iter.sv
// rtl/srl_iter.sv - iterative log-step logical/arithmetic right shifter with valid/ready handshakes
module srl_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  acc_next;
    logic [WIDTH-1:0]  fill_mask;
    logic [SH_W-1:0]   amt;
    logic [SH_W-1:0]   step;
    logic [SH_W-1:0]   sh;
    logic              fill;
    logic              over;
    logic              fill_in;
    logic              over_in;

    assign fill_in = arith & x[WIDTH-1];
    assign over_in = |y[WIDTH-1:SH_W];

    // amt is consumed LSB-first, so amt[0] always selects the current stage
    always_comb begin
        sh        = SH_W'(1) << step;
        fill_mask = ~({WIDTH{1'b1}} >> sh);
        acc_next  = acc;
        if (amt[0] && !over) begin
            acc_next = (acc >> sh) | (fill ? fill_mask : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            z         <= '0;
            acc       <= '0;
            amt       <= '0;
            step      <= '0;
            fill      <= 1'b0;
            over      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc      <= over_in ? {WIDTH{fill_in}} : x;
                        amt      <= y[SH_W-1:0];
                        fill     <= fill_in;
                        over     <= over_in;
                        step     <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc  <= acc_next;
                    amt  <= amt >> 1;
                    step <= step + 1'b1;
                    if (step == SH_W'(SH_W - 1)) begin
                        z         <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
